// File: rtl/alu_req_fifo.sv
// Request buffer in front of the ALU: a DEPTH-entry circular FIFO of {a, b, op}.
// The head entry is driven straight to the ALU operand/opcode inputs.
module alu_req_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_a,
    input  logic [DATA_W-1:0]          in_b,
    input  logic [OP_W-1:0]            in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          a,
    output logic [DATA_W-1:0]          b,
    output logic [OP_W-1:0]            op,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem_a_r [DEPTH];
    logic [DATA_W-1:0] mem_b_r [DEPTH];
    logic [OP_W-1:0]   mem_op_r[DEPTH];

    logic [PTR_W-1:0]  wp_r;
    logic [PTR_W-1:0]  rp_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              push_s;
    logic              pop_s;

    assign push_s    = in_valid && in_ready_r;
    assign pop_s     = out_valid_r && out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign count     = count_r;
    assign a         = mem_a_r[rp_r];
    assign b         = mem_b_r[rp_r];
    assign op        = mem_op_r[rp_r];

    // Next occupancy; flush overrides any handshake in the same cycle.
    always_comb begin
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = '0;
        end else if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, occupancy and the handshake flags (flags are registered from next occupancy).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_r        <= '0;
            rp_r        <= '0;
            count_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            in_ready_r  <= (count_nxt_s != CNT_FULL);
            out_valid_r <= (count_nxt_s != '0);
            if (flush) begin
                wp_r <= '0;
                rp_r <= '0;
            end else begin
                if (push_s) begin
                    wp_r <= wp_r + PTR_ONE;
                end else begin
                    wp_r <= wp_r;
                end
                if (pop_s) begin
                    rp_r <= rp_r + PTR_ONE;
                end else begin
                    rp_r <= rp_r;
                end
            end
        end
    end

    // Entry storage; a push that coincides with flush is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_r[i]  <= '0;
                mem_b_r[i]  <= '0;
                mem_op_r[i] <= '0;
            end
        end else if (push_s && !flush) begin
            mem_a_r[wp_r]  <= in_a;
            mem_b_r[wp_r]  <= in_b;
            mem_op_r[wp_r] <= in_op;
        end else begin
            mem_a_r[wp_r]  <= mem_a_r[wp_r];
            mem_b_r[wp_r]  <= mem_b_r[wp_r];
            mem_op_r[wp_r] <= mem_op_r[wp_r];
        end
    end

endmodule

// File: tb/tb_alu_req_fifo.sv
// Directed bench for alu_req_fifo: a vector table for handshake sequences
// plus hand-written streaming and asynchronous-reset sequences.
module tb_alu_req_fifo;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int OP_W   = 4;
    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [OP_W-1:0]   in_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [2:0]        count;

    int checks   = 0;
    int failures = 0;

    alu_req_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_op    (in_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              vld;
        logic [DATA_W-1:0] ia;
        logic [DATA_W-1:0] ib;
        logic [OP_W-1:0]   iop;
        logic              rdy;
        logic              fl;
        logic [2:0]        ecnt;
        logic              eir;
        logic              eov;
        logic              chk;
        logic [DATA_W-1:0] ea;
        logic [DATA_W-1:0] eb;
        logic [OP_W-1:0]   eop;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic vld, input int ia, input int ib, input logic [OP_W-1:0] iop,
                       input logic rdy, input logic fl, input int ecnt, input logic eir,
                       input logic eov, input logic chk, input int ea, input int eb,
                       input logic [OP_W-1:0] eop);
        vec_t v;
        v.vld = vld; v.ia = DATA_W'(ia); v.ib = DATA_W'(ib); v.iop = iop;
        v.rdy = rdy; v.fl = fl; v.ecnt = 3'(ecnt); v.eir = eir; v.eov = eov;
        v.chk = chk; v.ea = DATA_W'(ea); v.eb = DATA_W'(eb); v.eop = eop;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_flags(input string tag, input int ecnt, input logic eir, input logic eov);
        check({tag, ".count"}, int'(count), ecnt);
        check({tag, ".in_ready"}, int'(in_ready), int'(eir));
        check({tag, ".out_valid"}, int'(out_valid), int'(eov));
    endtask

    task automatic check_head(input string tag, input int ea, input int eb, input logic [OP_W-1:0] eop);
        check({tag, ".a"}, int'(a), ea);
        check({tag, ".b"}, int'(b), eb);
        check({tag, ".op"}, int'(op), int'(eop));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 16'd0; in_b = 16'd0; in_op = OP_ADD;

        // Reset then idle.
        repeat (2) @(negedge clk);
        check_flags("reset", 0, 1'b1, 1'b0);
        check_head("reset", 0, 0, OP_ADD);
        rst = 1'b0;
        @(posedge clk); #1;
        check_flags("idle", 0, 1'b1, 1'b0);

        // Fill with out_ready low, fifth offer ignored, then drain.
        add(1, 1, 2, OP_ADD, 0, 0, 1, 1, 1, 1, 1, 2, OP_ADD);
        add(1, 3, 4, OP_SUB, 0, 0, 2, 1, 1, 1, 1, 2, OP_ADD);
        add(1, 5, 6, OP_AND, 0, 0, 3, 1, 1, 1, 1, 2, OP_ADD);
        add(1, 7, 8, OP_OR,  0, 0, 4, 0, 1, 1, 1, 2, OP_ADD);
        add(1, 99, 99, OP_XOR, 0, 0, 4, 0, 1, 1, 1, 2, OP_ADD);
        add(0, 0, 0, OP_ADD, 1, 0, 3, 1, 1, 1, 3, 4, OP_SUB);
        add(0, 0, 0, OP_ADD, 1, 0, 2, 1, 1, 1, 5, 6, OP_AND);
        add(0, 0, 0, OP_ADD, 1, 0, 1, 1, 1, 1, 7, 8, OP_OR);
        add(0, 0, 0, OP_ADD, 1, 0, 0, 1, 0, 0, 0, 0, OP_ADD);
        // Simultaneous push/pop at count 2.
        add(1, 20, 21, OP_ADD, 0, 0, 1, 1, 1, 1, 20, 21, OP_ADD);
        add(1, 22, 23, OP_SUB, 0, 0, 2, 1, 1, 1, 20, 21, OP_ADD);
        add(1, 9, 10, OP_XOR,  1, 0, 2, 1, 1, 1, 22, 23, OP_SUB);
        add(0, 0, 0, OP_ADD,   1, 0, 1, 1, 1, 1, 9, 10, OP_XOR);
        add(0, 0, 0, OP_ADD,   1, 0, 0, 1, 0, 0, 0, 0, OP_ADD);
        // Push and pop offered while empty: only the push happens.
        add(1, 30, 31, OP_AND, 1, 0, 1, 1, 1, 1, 30, 31, OP_AND);
        add(0, 0, 0, OP_ADD,   1, 0, 0, 1, 0, 0, 0, 0, OP_ADD);
        // Push and pop offered while full: only the pop happens.
        add(1, 40, 41, OP_ADD, 0, 0, 1, 1, 1, 1, 40, 41, OP_ADD);
        add(1, 42, 43, OP_ADD, 0, 0, 2, 1, 1, 1, 40, 41, OP_ADD);
        add(1, 44, 45, OP_ADD, 0, 0, 3, 1, 1, 1, 40, 41, OP_ADD);
        add(1, 46, 47, OP_ADD, 0, 0, 4, 0, 1, 1, 40, 41, OP_ADD);
        add(1, 48, 49, OP_ADD, 1, 0, 3, 1, 1, 1, 42, 43, OP_ADD);
        add(0, 0, 0, OP_ADD,   1, 0, 2, 1, 1, 1, 44, 45, OP_ADD);
        add(0, 0, 0, OP_ADD,   1, 0, 1, 1, 1, 1, 46, 47, OP_ADD);
        add(0, 0, 0, OP_ADD,   1, 0, 0, 1, 0, 0, 0, 0, OP_ADD);
        // Flush with a concurrent push at count 3.
        add(1, 50, 51, OP_ADD, 0, 0, 1, 1, 1, 1, 50, 51, OP_ADD);
        add(1, 52, 53, OP_ADD, 0, 0, 2, 1, 1, 1, 50, 51, OP_ADD);
        add(1, 54, 55, OP_ADD, 0, 0, 3, 1, 1, 1, 50, 51, OP_ADD);
        add(1, 11, 12, OP_ADD, 1, 1, 0, 1, 0, 0, 0, 0, OP_ADD);
        add(1, 60, 61, OP_SUB, 0, 0, 1, 1, 1, 1, 60, 61, OP_SUB);
        add(0, 0, 0, OP_ADD,   1, 0, 0, 1, 0, 0, 0, 0, OP_ADD);

        foreach (vq[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            in_valid = vq[i].vld; in_a = vq[i].ia; in_b = vq[i].ib; in_op = vq[i].iop;
            out_ready = vq[i].rdy; flush = vq[i].fl;
            @(posedge clk); #1;
            check_flags(tag, int'(vq[i].ecnt), vq[i].eir, vq[i].eov);
            if (vq[i].chk) check_head(tag, int'(vq[i].ea), int'(vq[i].eb), vq[i].eop);
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

        // Continuous streaming, 10 requests: each head is the request just pushed.
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_a = DATA_W'(i); in_b = DATA_W'(2 * i); in_op = OP_W'(i % 5);
            @(posedge clk); #1;
            check_flags($sformatf("stream%0d", i), 1, 1'b1, 1'b1);
            check_head($sformatf("stream%0d", i), i, 2 * i, OP_W'(i % 5));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_flags("stream_end", 0, 1'b1, 1'b0);

        // Asynchronous reset while holding 3 entries with a pop pending.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = DATA_W'(70 + i); in_b = DATA_W'(80 + i); in_op = OP_OR;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check_flags("pre_rst", 3, 1'b1, 1'b1);
        #3 rst = 1'b1;
        #1;
        check_flags("mid_rst", 0, 1'b1, 1'b0);
        check_head("mid_rst", 0, 0, OP_ADD);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'd13; in_b = 16'd14; in_op = OP_SUB;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_flags("post_rst", 1, 1'b1, 1'b1);
        check_head("post_rst", 13, 14, OP_SUB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
